// File: rtl/rfarb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The optional RFARB_STALL_CNT_EN build adds a stall-cycle counter to regfile_wport_arb.
package rfarb_pkg;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_AUX  = 2'd2
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rfarb_fifo.sv
// Small synchronous FIFO buffering auxiliary register writes.
// DEPTH must be a power of two so the pointers wrap on their own.
module rfarb_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wport_arb.sv
// Arbitrates the register-file write port between pipeline writeback and a buffered auxiliary path.
// Define RFARB_STALL_CNT_EN to add the stall_cycles_out counter.
module regfile_wport_arb
    import rfarb_pkg::*;
#(
    parameter int DATA_W     = rfarb_pkg::DATA_W,
    parameter int ADDR_W     = rfarb_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_valid_in,
    input  logic [ADDR_W-1:0]            wb_waddr_in,
    input  logic [DATA_W-1:0]            wb_wdata_in,
    output logic                         wb_stall_out,
    input  logic                         aux_valid_in,
    output logic                         aux_ready_out,
    input  logic [ADDR_W-1:0]            aux_waddr_in,
    input  logic [DATA_W-1:0]            aux_wdata_in,
    output logic                         rf_we_out,
    output logic [ADDR_W-1:0]            rf_waddr_out,
    output logic [DATA_W-1:0]            rf_wdata_out,
    output logic [$clog2(FIFO_DEPTH):0]  aux_count_out
`ifdef RFARB_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cycles_out
`endif
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [ENTRY_W-1:0]  head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                force_aux;
    logic [STARVE_W-1:0] starve;
    grant_e              grant;

    rfarb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (aux_valid_in && aux_ready_out),
        .push_data ({aux_waddr_in, aux_wdata_in}),
        .pop       (grant == GNT_AUX),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (aux_count_out)
    );

    assign aux_ready_out = !fifo_full;
    assign force_aux     = !fifo_empty && (starve == STARVE_W'(STARVE_MAX));
    assign wb_stall_out  = force_aux;

    // Pipeline wins unless the auxiliary queue has been starved long enough.
    always_comb begin
        grant = GNT_NONE;
        if (!fifo_empty && (force_aux || !wb_valid_in)) begin
            grant = GNT_AUX;
        end else if (wb_valid_in) begin
            grant = GNT_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_out    <= 1'b0;
            rf_waddr_out <= '0;
            rf_wdata_out <= '0;
        end else begin
            rf_we_out <= (grant != GNT_NONE);
            case (grant)
                GNT_WB: begin
                    rf_waddr_out <= wb_waddr_in;
                    rf_wdata_out <= wb_wdata_in;
                end
                GNT_AUX: begin
                    rf_waddr_out <= head[ENTRY_W-1:DATA_W];
                    rf_wdata_out <= head[DATA_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Counts consecutive lost cycles of a non-empty queue, saturating at the force threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= '0;
        end else if (fifo_empty || grant == GNT_AUX) begin
            starve <= '0;
        end else if (grant == GNT_WB && starve != STARVE_W'(STARVE_MAX)) begin
            starve <= starve + 1'b1;
        end
    end

`ifdef RFARB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_out <= '0;
        end else if (wb_stall_out && stall_cycles_out != 16'hFFFF) begin
            stall_cycles_out <= stall_cycles_out + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Self-checking bench for regfile_wport_arb: directed scenarios then random traffic against a queue model.
// Build with RFARB_STALL_CNT_EN defined to also check stall_cycles_out.
module tb_regfile_wport_arb;

    localparam int DW = 24;
    localparam int AW = 4;
    localparam int DEPTH = 2;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid_in;
    logic [AW-1:0] wb_waddr_in;
    logic [DW-1:0] wb_wdata_in;
    logic          wb_stall_out;
    logic          aux_valid_in;
    logic          aux_ready_out;
    logic [AW-1:0] aux_waddr_in;
    logic [DW-1:0] aux_wdata_in;
    logic          rf_we_out;
    logic [AW-1:0] rf_waddr_out;
    logic [DW-1:0] rf_wdata_out;
    logic [1:0]    aux_count_out;
`ifdef RFARB_STALL_CNT_EN
    logic [15:0]   stall_cycles_out;
`endif

    regfile_wport_arb #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid_in   (wb_valid_in),
        .wb_waddr_in   (wb_waddr_in),
        .wb_wdata_in   (wb_wdata_in),
        .wb_stall_out  (wb_stall_out),
        .aux_valid_in  (aux_valid_in),
        .aux_ready_out (aux_ready_out),
        .aux_waddr_in  (aux_waddr_in),
        .aux_wdata_in  (aux_wdata_in),
        .rf_we_out     (rf_we_out),
        .rf_waddr_out  (rf_waddr_out),
        .rf_wdata_out  (rf_wdata_out),
        .aux_count_out (aux_count_out)
`ifdef RFARB_STALL_CNT_EN
        ,
        .stall_cycles_out (stall_cycles_out)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: a queue of pending aux writes plus a count of cycles the queue has lost.
    rfarb_pkg::wr_req_t q[$];
    int          starve = 0;
    logic        m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int          m_stall_cnt = 0;
    bit          m_stall, m_ready, m_wb_taken, m_aux_taken, m_aux_granted;
    logic        obs_stall, obs_ready;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic wv, input logic [AW-1:0] wa,
                                  input logic [DW-1:0] wd, input logic av,
                                  input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        rfarb_pkg::wr_req_t item;
        bit had;
        @(negedge clk);
        rst = r; wb_valid_in = wv; wb_waddr_in = wa; wb_wdata_in = wd;
        aux_valid_in = av; aux_waddr_in = aa; aux_wdata_in = ad;
        #1;
        m_ready = (q.size() < DEPTH);
        m_stall = (q.size() > 0) && (starve == SMAX);
        obs_stall = wb_stall_out;
        obs_ready = aux_ready_out;
        check_output("aux_ready", aux_ready_out, m_ready);
        check_output("wb_stall", wb_stall_out, m_stall);
        check_output("aux_count", aux_count_out, q.size());
        @(posedge clk);
        m_wb_taken = 0; m_aux_taken = 0; m_aux_granted = 0;
        if (r) begin
            q.delete(); starve = 0; m_we = 0; m_addr = '0; m_data = '0; m_stall_cnt = 0;
        end else begin
            had = (q.size() > 0);
            if (had && (m_stall || !wv)) begin
                item = q.pop_front();
                m_we = 1; m_addr = item.addr; m_data = item.data; starve = 0;
                m_aux_granted = 1;
            end else if (wv) begin
                m_we = 1; m_addr = wa; m_data = wd; m_wb_taken = 1;
                starve = had ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
            end else begin
                m_we = 0; starve = 0;
            end
            if (av && m_ready) begin
                q.push_back('{addr: aa, data: ad});
                m_aux_taken = 1;
            end
            if (m_stall && m_stall_cnt < 65535) m_stall_cnt++;
        end
        #1;
        check_output("rf_we", rf_we_out, m_we);
        check_output("rf_waddr", rf_waddr_out, m_addr);
        check_output("rf_wdata", rf_wdata_out, m_data);
`ifdef RFARB_STALL_CNT_EN
        check_output("stall_cycles", stall_cycles_out, m_stall_cnt);
`endif
    endtask

    initial begin
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] aux_order[$];
        int idx, stall_at, cyc;
        bit done, pend;

        rst = 1'b1; wb_valid_in = 0; wb_waddr_in = '0; wb_wdata_in = '0;
        aux_valid_in = 0; aux_waddr_in = '0; aux_wdata_in = '0;
        repeat (2) @(posedge clk);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0);

        $display("[TB] pipeline only");
        apply_stimulus(0, 1, 4'd3, 24'h00ABCD, 0, 0, 0);
        check_output("wb_only_we", rf_we_out, 1);
        check_output("wb_only_addr", rf_waddr_out, 3);
        check_output("wb_only_data", rf_wdata_out, 24'h00ABCD);

        $display("[TB] idle auxiliary");
        apply_stimulus(0, 0, 0, 0, 1, 4'd5, 24'h123456);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("aux_idle_we", rf_we_out, 1);
        check_output("aux_idle_addr", rf_waddr_out, 5);
        check_output("aux_idle_data", rf_wdata_out, 24'h123456);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("aux_idle_count", aux_count_out, 0);

        $display("[TB] fifo full");
        idx = 0; done = 0; wa = 4'hE; wd = 24'h0;
        for (cyc = 0; cyc < 40 && !done; cyc++) begin
            apply_stimulus(0, 1, wa, wd, idx < 3, 4'(idx + 1), 24'(idx * 17 + 1));
            if (idx == 2 && !m_aux_taken && aux_order.size() == 0)
                check_output("full_third_ready", obs_ready, 0);
            if (m_aux_granted) aux_order.push_back(rf_waddr_out);
            if (m_aux_taken) idx++;
            if (m_wb_taken) begin wa = 4'(wa + 1); wd = 24'($urandom); end
            done = (idx == 3) && (q.size() == 0);
        end
        check_output("full_done", done, 1);
        check_output("full_order_n", aux_order.size(), 3);
        for (int i = 0; i < aux_order.size(); i++)
            check_output("full_order_addr", aux_order[i], i + 1);

        $display("[TB] reset mid-operation");
        apply_stimulus(0, 1, 4'd9, 24'h1, 1, 4'd10, 24'h2);
        apply_stimulus(0, 1, 4'd9, 24'h1, 1, 4'd11, 24'h3);
        apply_stimulus(1, 1, 4'd9, 24'h1, 0, 0, 0);
        check_output("rst_mid_count", aux_count_out, 0);
        check_output("rst_mid_we", rf_we_out, 0);
        check_output("rst_mid_ready", aux_ready_out, 1);
        for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] starvation x3");
        for (int rep = 0; rep < 3; rep++) begin
            wa = 4'(rep + 1); wd = 24'($urandom);
            apply_stimulus(0, 1, wa, wd, 1, 4'd7, 24'(rep + 100));
            wa = 4'(rep + 8); wd = 24'($urandom);
            stall_at = 0;
            for (int k = 1; k <= 12; k++) begin
                apply_stimulus(0, 1, wa, wd, 0, 0, 0);
                if (stall_at != 0 && k == stall_at + 1) begin
                    check_output("starve_held_wb_addr", rf_waddr_out, wa);
                    check_output("starve_held_wb_data", rf_wdata_out, wd);
                end
                if (obs_stall && stall_at == 0) begin
                    stall_at = k;
                    check_output("starve_aux_addr", rf_waddr_out, 7);
                end
                if (m_wb_taken) begin wa = 4'(wa + 1); wd = 24'($urandom); end
            end
            check_output("starve_stall_cycle", stall_at, 5);
            apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        end
`ifdef RFARB_STALL_CNT_EN
        check_output("stall_cnt_three", stall_cycles_out, 3);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0);
        check_output("stall_cnt_reset", stall_cycles_out, 0);
`endif

        $display("[TB] random traffic");
        pend = 0; wa = '0; wd = '0;
        for (int i = 0; i < 500; i++) begin
            logic r, wv;
            r = ($urandom_range(0, 63) == 0);
            if (pend) wv = 1;
            else begin
                wv = ($urandom_range(0, 3) != 0);
                wa = 4'($urandom); wd = 24'($urandom);
            end
            apply_stimulus(r, wv, wa, wd, 1'($urandom), 4'($urandom), 24'($urandom));
            pend = !r && wv && !m_wb_taken;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
